// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [2:0] SEL_DEFAULT = 3'b100;

    // Bit periods in one frame: start + data + optional parity + stop bits.
    function automatic int frame_ticks(input int data_bits, input int parity_en, input int stop_bits);
        return 1 + data_bits + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART frame sequencer driving the baud divider select/reset and Tx pin
module uart_tx_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_select,
    output logic [2:0] o_baud_sel,
    output logic       o_baud_rst,
    input  logic       i_baud_tick,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_frame_done
);
    import uart_pkg::*;

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_parity;
    logic       r_tx;
    logic       r_tx_ready;
    logic       r_frame_done;
    logic       r_baud_rst;
    logic [2:0] r_baud_sel;

    logic [7:0] w_shift_next;
    logic [2:0] w_bit_cnt_next;
    logic       w_parity_next;
    logic       w_tx_next;
    logic       w_tx_ready_next;
    logic       w_frame_done_next;
    logic       w_baud_rst_next;
    logic [2:0] w_baud_sel_next;

    logic       w_accept;
    logic       w_tick;
    logic [7:0] w_data_masked;

    assign w_accept      = i_tx_valid & r_tx_ready;
    // The divider is being realigned while BaudRst is high, so any strobe then is stale.
    assign w_tick        = i_baud_tick & ~r_baud_rst;
    assign w_data_masked = i_tx_data & DATA_MASK;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_shift      <= 8'd0;
            r_bit_cnt    <= 3'd0;
            r_parity     <= 1'b0;
            r_tx         <= 1'b1;
            r_tx_ready   <= 1'b0;
            r_frame_done <= 1'b0;
            r_baud_rst   <= 1'b0;
            r_baud_sel   <= SEL_DEFAULT;
        end else begin
            r_state      <= w_state_next;
            r_shift      <= w_shift_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_parity     <= w_parity_next;
            r_tx         <= w_tx_next;
            r_tx_ready   <= w_tx_ready_next;
            r_frame_done <= w_frame_done_next;
            r_baud_rst   <= w_baud_rst_next;
            r_baud_sel   <= w_baud_sel_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = START;
            START:   if (w_tick) w_state_next = DATA;
            DATA:    if (w_tick && r_bit_cnt == LAST_BIT)
                         w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (w_tick) w_state_next = STOP;
            STOP:    if (w_tick && r_bit_cnt == LAST_STOP) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_shift_next      = r_shift;
        w_bit_cnt_next    = r_bit_cnt;
        w_parity_next     = r_parity;
        w_tx_next         = r_tx;
        w_tx_ready_next   = r_tx_ready;
        w_frame_done_next = 1'b0;
        w_baud_rst_next   = 1'b0;
        w_baud_sel_next   = r_baud_sel;
        case (r_state)
            IDLE: begin
                w_tx_next       = 1'b1;
                w_tx_ready_next = 1'b1;
                if (w_accept) begin
                    w_tx_ready_next = 1'b0;
                    w_baud_rst_next = 1'b1;
                    w_baud_sel_next = i_select;
                    w_shift_next    = w_data_masked;
                    w_parity_next   = ^w_data_masked;
                end
            end
            START: begin
                if (r_baud_rst) w_tx_next = 1'b0;
                if (w_tick) begin
                    w_tx_next      = r_shift[0];
                    w_bit_cnt_next = 3'd0;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_tx_next      = (PARITY_EN != 0) ? r_parity : 1'b1;
                        w_bit_cnt_next = 3'd0;
                    end else begin
                        w_tx_next      = r_shift[1];
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_tx_next      = 1'b1;
                    w_bit_cnt_next = 3'd0;
                end
            end
            STOP: begin
                w_tx_next = 1'b1;
                if (w_tick) begin
                    if (r_bit_cnt == LAST_STOP) begin
                        w_frame_done_next = 1'b1;
                        w_tx_ready_next   = 1'b1;
                        w_bit_cnt_next    = 3'd0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end
            end
            default: w_tx_next = 1'b1;
        endcase
    end

    assign o_tx         = r_tx;
    assign o_tx_ready   = r_tx_ready;
    assign o_frame_done = r_frame_done;
    assign o_baud_rst   = r_baud_rst;
    assign o_baud_sel   = r_baud_sel;
    assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl over three parameter sets
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    localparam int NI = 3;
    localparam int DB [NI] = '{8, 8, 5};
    localparam int PE [NI] = '{0, 1, 1};
    localparam int SB [NI] = '{1, 2, 1};

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    select;
    logic          tick;
    logic [7:0]    data;
    logic [NI-1:0] valid;
    logic [NI-1:0] ready;
    logic [NI-1:0] tx;
    logic [NI-1:0] busy;
    logic [NI-1:0] fd;
    logic [NI-1:0] brst;
    logic [2:0]    bsel [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_select(select), .o_baud_sel(bsel[0]),
        .o_baud_rst(brst[0]), .i_baud_tick(tick), .i_tx_data(data),
        .i_tx_valid(valid[0]), .o_tx_ready(ready[0]), .o_tx(tx[0]),
        .o_busy(busy[0]), .o_frame_done(fd[0]));

    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_select(select), .o_baud_sel(bsel[1]),
        .o_baud_rst(brst[1]), .i_baud_tick(tick), .i_tx_data(data),
        .i_tx_valid(valid[1]), .o_tx_ready(ready[1]), .o_tx(tx[1]),
        .o_busy(busy[1]), .o_frame_done(fd[1]));

    uart_tx_ctrl #(.DATA_BITS(5), .PARITY_EN(1), .STOP_BITS(1)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_select(select), .o_baud_sel(bsel[2]),
        .o_baud_rst(brst[2]), .i_baud_tick(tick), .i_tx_data(data),
        .i_tx_valid(valid[2]), .o_tx_ready(ready[2]), .o_tx(tx[2]),
        .o_busy(busy[2]), .o_frame_done(fd[2]));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            chk("idle_tx", 8'(tx), 8'(3'b111));
            chk("idle_busy", 8'(busy), 8'd0);
            chk("idle_frame_done", 8'(fd), 8'd0);
        end
        tick = 1'b0;
    endtask

    // Entered and left at a negedge; the expected line levels come from the frame format alone.
    task automatic run_frame(input int k, input logic [7:0] d, input logic [2:0] sel,
                             input int tper, input bit keep_valid, input int abort_at);
        logic exp_bits [$];
        int   ones;
        exp_bits = {};
        ones = 0;
        exp_bits.push_back(1'b0);
        for (int b = 0; b < DB[k]; b++) begin
            exp_bits.push_back(d[b]);
            ones += int'(d[b]);
        end
        if (PE[k] != 0) exp_bits.push_back(1'(ones % 2));
        for (int s = 0; s < SB[k]; s++) exp_bits.push_back(1'b1);

        chk("ready_before_accept", 8'(ready[k]), 8'd1);
        data = d;
        select = sel;
        valid[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("accept_busy", 8'(busy[k]), 8'd1);
        chk("accept_ready", 8'(ready[k]), 8'd0);
        chk("accept_baud_rst", 8'(brst[k]), 8'd1);
        chk("accept_baud_sel", 8'(bsel[k]), 8'(sel));
        chk("accept_tx_idle", 8'(tx[k]), 8'd1);
        chk("accept_frame_done", 8'(fd[k]), 8'd0);
        if (!keep_valid) valid[k] = 1'b0;
        data = 8'($urandom);
        select = ~sel;
        tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tick = 1'b0;
        chk("baud_rst_pulse_end", 8'(brst[k]), 8'd0);
        for (int i = 0; i < exp_bits.size(); i++) begin
            for (int c = 0; c < tper; c++) begin
                if (i == abort_at && c == 1) begin
                    #2 rst = 1'b1;
                    #1;
                    return;
                end
                chk($sformatf("tx_bit%0d_k%0d", i, k), 8'(tx[k]), 8'(exp_bits[i]));
                chk("mid_frame_done", 8'(fd[k]), 8'd0);
                chk("mid_baud_sel", 8'(bsel[k]), 8'(sel));
                tick = (c == tper - 1);
                @(posedge clk);
                @(negedge clk);
                tick = 1'b0;
            end
        end
        chk("done_pulse", 8'(fd[k]), 8'd1);
        chk("done_busy", 8'(busy[k]), 8'd0);
        chk("done_ready", 8'(ready[k]), 8'd1);
        chk("done_tx", 8'(tx[k]), 8'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        select = 3'd0;
        tick = 1'b0;
        data = 8'd0;
        valid = '0;
        @(negedge clk);
        chk("rst_tx", 8'(tx), 8'(3'b111));
        chk("rst_ready", 8'(ready), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_frame_done", 8'(fd), 8'd0);
        chk("rst_baud_rst", 8'(brst), 8'd0);
        for (int k = 0; k < NI; k++) chk("rst_baud_sel", 8'(bsel[k]), 8'(SEL_DEFAULT));
        rst = 1'b0;
        #1 chk("ready_before_first_edge", 8'(ready), 8'd0);
        @(posedge clk);
        @(negedge clk);
        chk("ready_first_edge", 8'(ready), 8'(3'b111));
        idle_cycles(20);

        run_frame(0, 8'h55, 3'b100, 4, 1'b0, -1);
        idle_cycles(3);
        run_frame(1, 8'h07, 3'b010, 4, 1'b0, -1);
        idle_cycles(2);
        run_frame(0, 8'h5A, 3'b011, 3, 1'b0, -1);
        idle_cycles(2);
        run_frame(0, 8'hA5, 3'b001, 4, 1'b1, -1);
        run_frame(0, 8'h3C, 3'b110, 4, 1'b0, -1);
        idle_cycles(2);

        run_frame(0, 8'hC3, 3'b101, 4, 1'b0, 4);
        valid = '0;
        tick = 1'b0;
        chk("abort_tx", 8'(tx), 8'(3'b111));
        chk("abort_busy", 8'(busy), 8'd0);
        chk("abort_frame_done", 8'(fd), 8'd0);
        chk("abort_baud_sel", 8'(bsel[0]), 8'(SEL_DEFAULT));
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready_low", 8'(ready), 8'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("post_abort_frame_done", 8'(fd), 8'd0);
            chk("post_abort_ready", 8'(ready), 8'(3'b111));
        end
        run_frame(0, 8'hFF, 3'b010, 4, 1'b0, -1);

        for (int n = 0; n < 12; n++) begin
            idle_cycles(int'($urandom_range(0, 3)));
            run_frame(int'($urandom_range(0, NI - 1)), 8'($urandom), 3'($urandom),
                      int'($urandom_range(2, 5)), 1'b0, -1);
        end
        idle_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
